// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle MIPS-subset control sequencer: fetch/decode/execute/memory/writeback for the shared datapath.
// Latency: Moore outputs from the registered state; R/I-type 4, lw 5, sw 4, branch/jump 3 cycles plus memory stalls.
// Backpressure: FETCH, MEM_RD and MEM_WR hold while mem_ready=0; mem_ready is ignored in every other state.
//
// Ports: clk/rst_n (sync, active-low); opcode/funct from the IR; flagz/flagn from the ALU; mem_ready from memory;
// datapath controls alu_control, alu_src_a/b, iord, mem_read/write, ir_write, pc_write, pc_source,
// reg_write, reg_dst, mem_to_reg; status instr_done, illegal (sticky) and debug state.
module alu_ctrl_fsm #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       flagz,
    input  logic       flagn,
    input  logic       mem_ready,
    output logic [2:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q, state_nxt;
    logic   illegal_q, illegal_nxt;
    logic   r_legal;
    logic [2:0] r_alu, i_alu;
    logic   bad_instr;

    // The FSM never looks at the sign flag; it is kept on the port list for the datapath contract.
    logic unused_flagn;
    assign unused_flagn = flagn;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            illegal_q <= illegal_nxt;
        end
    end

    // ALU code lookup for R-type funct and I-type opcode.
    always_comb begin
        r_legal = 1'b1;
        r_alu   = 3'b010;
        case (funct)
            6'b100000: r_alu = 3'b010;
            6'b100010: r_alu = 3'b110;
            6'b100100: r_alu = 3'b000;
            6'b100101: r_alu = 3'b001;
            6'b100111: r_alu = 3'b100;
            6'b101010: r_alu = 3'b111;
            6'b011000: r_alu = 3'b011;
            default:   r_legal = 1'b0;
        endcase
        i_alu = 3'b010;
        case (opcode)
            OP_SLTI: i_alu = 3'b111;
            OP_ANDI: i_alu = 3'b000;
            OP_ORI:  i_alu = 3'b001;
            default: i_alu = 3'b010;
        endcase
    end

    always_comb begin
        state_nxt   = state_q;
        illegal_nxt = illegal_q;
        bad_instr   = 1'b0;
        alu_control = 3'b010;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_source   = 2'b00;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        instr_done  = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:                    state_nxt = S_MEM_ADDR;
                    OP_RTYPE: begin
                        if (r_legal) state_nxt = S_EXEC_R;
                        else         bad_instr = 1'b1;
                    end
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_nxt = S_EXEC_I;
                    OP_BEQ, OP_BNE:                  state_nxt = S_BRANCH;
                    OP_J:                            state_nxt = S_JUMP;
                    default:                         bad_instr = 1'b1;
                endcase
                if (bad_instr) begin
                    illegal_nxt = 1'b1;
                    state_nxt   = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a   = 1'b1;
                alu_control = r_alu;
                state_nxt   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = i_alu;
                state_nxt   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_RTYPE);
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                // The store is the last cycle only once memory accepts it.
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_source   = 2'b01;
                instr_done  = 1'b1;
                pc_write    = (opcode == OP_BEQ) ? flagz : ~flagz;
                state_nxt   = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_TRAP: begin
                alu_control = 3'b000;
            end
            default: state_nxt = S_FETCH;
        endcase

        // Reset is synchronous, so the registered state lags it; force every control quiet meanwhile.
        if (!rst_n) begin
            alu_control = 3'b000;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            iord        = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_source   = 2'b00;
            reg_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            instr_done  = 1'b0;
        end
    end

    assign illegal = rst_n & illegal_q;
    assign state   = rst_n ? state_q : 4'd0;

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multi-cycle control sequencer that drives the 3-bit ALU control code and consumes the ALU's flagz/flagn results.
- Decodes the MIPS-subset opcode/funct held in the instruction register.
- Steps the shared datapath through fetch, decode, execute, memory and writeback.
- Stalls on a memory-ready handshake. Sits between the instruction register and the datapath mux/enable controls.

Parameters:
TRAP_ON_ILLEGAL, 1, 1: an illegal opcode/funct parks the FSM in TRAP; 0: the instruction is treated as a NOP (DECODE->FETCH). The sticky flag is set in both cases.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset; the only clock is clk
opcode  in  6  IR[31:26]; stable from DECODE until the next fetch completes
funct  in  6  IR[5:0]
flagz  in  1  ALU zero flag (combinational, same cycle)
flagn  in  1  ALU negative flag (unused by the FSM; reserved)
mem_ready  in  1  memory completes the current read/write this cycle
alu_control  out  3  010 add, 110 sub, 111 slt, 000 and, 001 or, 011 mul, 100 nor
alu_src_a  out  1  0 PC, 1 A register
alu_src_b  out  2  00 B, 01 constant 4, 10 extended imm, 11 imm<<2
iord  out  1  memory address: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load the IR
pc_write  out  1  load the PC
pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target
reg_write  out  1  register-file write enable
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 ALUOut, 1 MDR
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal  out  1  sticky illegal-instruction flag
state  out  4  current state, for debug

Behaviour:
- Reset: sampled on rising clk with rst_n=0.
  - state=FETCH, illegal=0.
  - All outputs are 0 while rst_n=0; alu_control is also 0 during reset.
  - A reset mid-instruction aborts it, with no partial write asserted afterwards.
- Outputs:
  - Decoded combinationally from the registered state (Moore).
  - Exceptions: pc_write/ir_write in FETCH depend on mem_ready; pc_write in BRANCH depends on flagz.
  - Any output not listed for a state is 0; alu_control defaults to 010.
- States and transitions:
  - FETCH: mem_read=1, iord=0, src_a=0, src_b=01, alu=010. If mem_ready: ir_write=1, pc_write=1, pc_source=00 -> DECODE. Otherwise hold, with ir_write/pc_write=0.
  - DECODE: src_a=0, src_b=11, alu=010 (branch target into ALUOut). Next state by opcode:
    - lw 100011 / sw 101011 -> MEM_ADDR
    - 000000 with legal funct -> EXEC_R
    - addi 001000, slti 001010, andi 001100, ori 001101 -> EXEC_I
    - beq 000100, bne 000101 -> BRANCH
    - j 000010 -> JUMP
    - otherwise: illegal<=1, then TRAP (or FETCH if TRAP_ON_ILLEGAL=0)
  - EXEC_R: src_a=1, src_b=00. funct map: 100000->010, 100010->110, 100100->000, 100101->001, 100111->100, 101010->111, 011000->011. Next: ALU_WB.
  - EXEC_I: src_a=1, src_b=10. alu: addi 010, slti 111, andi 000, ori 001. Next: ALU_WB. The datapath zero-extends for andi/ori.
  - ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=1 for R-type and 0 for I-type; instr_done=1 -> FETCH.
  - MEM_ADDR: src_a=1, src_b=10, alu=010. lw -> MEM_RD, sw -> MEM_WR.
  - MEM_RD: mem_read=1, iord=1; hold until mem_ready -> MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
  - MEM_WR: mem_write=1, iord=1; hold until mem_ready, then instr_done=1 -> FETCH.
  - BRANCH: src_a=1, src_b=00, alu=110, pc_source=01, instr_done=1. pc_write = (beq & flagz) | (bne & ~flagz). Next: FETCH.
  - JUMP: pc_write=1, pc_source=10, instr_done=1 -> FETCH.
  - TRAP: all outputs 0, illegal=1; exit only by reset.
- Cycle counts with mem_ready tied to 1:
  - R-type and I-type ALU: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne and j: 3 cycles
  - Each extra cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- illegal clears only on reset.

Test Plan:
- Reset with mem_ready=1 -> all outputs 0 during reset; first post-reset cycle state=FETCH, mem_read=1, alu_control=010, src_b=01.
- R-type sub (opcode 000000, funct 100010), mem_ready=1 -> EXEC_R drives alu_control=110; ALU_WB has reg_write=1, reg_dst=1; instr_done pulses in cycle 4.
- lw with mem_ready held low 2 cycles in MEM_RD -> 7 total cycles; mem_read=1, iord=1 throughout MEM_RD; MEM_WB has mem_to_reg=1.
- beq with flagz=1 -> pc_write=1, pc_source=01. beq with flagz=0 -> pc_write=0. bne with flagz=0 -> pc_write=1.
- Opcode 111111 with TRAP_ON_ILLEGAL=1 -> illegal=1, FSM stuck in TRAP, all controls 0. Same opcode with TRAP_ON_ILLEGAL=0 -> back in FETCH after DECODE, illegal=1.
- rst_n=0 asserted in MEM_WR -> next cycle mem_write=0 and state=FETCH after release.
